glow_envelope: RTL and testbench
================================

# glow_envelope

Upstream brightness-envelope generator for the LED glow path on the TinyFPGA BX. A prescaled state machine ramps an unsigned brightness level up, holds it, ramps it down, and holds it off, repeating while enabled. LEVEL feeds the downstream first-order PWM/sigma-delta stage directly as its duty input. Rise and fall rates and hold times are run-time inputs, so the glow shape can change without resynthesis.

## Interface
- LEVEL_W, 5: width of LEVEL; LEVEL_MAX = 2^LEVEL_W − 1 (31 at default).
- DIV_W, 16: prescaler width.
- HOLD_W, 8: hold-step counter width.

- CLK  in  1  system clock (16 MHz).
- RST  in  1  reset, asynchronous, active-high.
- ENABLE  in  1  run the envelope; deassertion triggers a graceful fade-out.
- RISE_DIV  in  DIV_W  step period minus 1, in clocks, for RISE and HOLD_HI.
- FALL_DIV  in  DIV_W  step period minus 1, in clocks, for FALL and HOLD_LO.
- HOLD_HIGH  in  HOLD_W  steps spent at LEVEL_MAX; 0 skips HOLD_HI.
- HOLD_LOW  in  HOLD_W  steps spent at 0; 0 skips HOLD_LO.
- LEVEL  out  LEVEL_W  brightness to the PWM stage.
- LEVEL_STB  out  1  one-cycle pulse, registered together with every LEVEL change.
- STATE  out  3  current state encoding.
- CYCLE_DONE  out  1  one-cycle pulse when FALL exits.

## Operation
- States: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4. Encodings 5–7 are illegal and recover to IDLE on the next edge.
- Prescaler counter pc:
  - Selected divisor div is RISE_DIV in RISE and HOLD_HI, FALL_DIV in FALL and HOLD_LO.
  - tick = (pc >= div). On tick pc←0, else pc←pc+1.
  - The `>=` compare means a divisor lowered mid-count takes effect without wrap.
  - pc←0 on every state change.
- Hold counter hc: cleared on entering a hold state; increments on tick.
- IDLE: LEVEL=0. ENABLE=1 → RISE.
- RISE: on tick LEVEL←LEVEL+1 and LEVEL_STB=1. When the new LEVEL equals LEVEL_MAX → HOLD_HI, or → FALL if HOLD_HIGH=0.
- HOLD_HI: on tick, if hc+1 ≥ HOLD_HIGH → FALL.
- FALL: on tick LEVEL←LEVEL−1 and LEVEL_STB=1. When the new LEVEL is 0: CYCLE_DONE=1, then → HOLD_LO (→ RISE if HOLD_LOW=0); → IDLE instead if ENABLE=0.
- HOLD_LO: on tick, if hc+1 ≥ HOLD_LOW → RISE.
- ENABLE=0 while in RISE or HOLD_HI → FALL on the next edge. LEVEL is kept and fades from its current value.
- ENABLE=0 while in HOLD_LO → IDLE on the next edge.
- ENABLE=0 while in FALL: fade continues to 0, then → IDLE.
- ENABLE re-asserted during a fade-out is ignored until IDLE is reached; IDLE then restarts RISE.
- Arithmetic is unsigned. LEVEL never wraps: the increment only occurs below LEVEL_MAX and the decrement only above 0.
- Config inputs are used live with no internal latching. Software changes them only in IDLE for glitch-free shapes.

## Timing
- All outputs are registered.
- Reset values: LEVEL=0, LEVEL_STB=0, STATE=IDLE, CYCLE_DONE=0, pc=0, hc=0.
- Reset mid-ramp forces the reset values asynchronously. The first post-reset action is IDLE evaluation.
- IDLE→RISE takes 1 cycle after ENABLE is sampled high.
- In RISE/FALL, LEVEL changes every div+1 cycles. The first change comes div+1 cycles after state entry.
- Full ramp 0→31 takes 31·(RISE_DIV+1) cycles. A hold lasts HOLD_x·(div+1) cycles.
- Ramp end and state change happen on the same edge: LEVEL=31 and STATE=HOLD_HI appear together.

## Structure
- Package glow_pkg: state encoding constants, and a LEVEL_MAX function of LEVEL_W.
- Sub-module glow_prescaler contains the pc counter, `>=` compare and tick output, with inputs div and restart. It is reused by future pattern blocks.
- The top level holds the FSM, hc and the LEVEL datapath.

## Test plan
- Reset, ENABLE=0 → LEVEL=0, STATE=0, no strobes for 1000 cycles.
- RISE_DIV=3, FALL_DIV=1, HOLD_HIGH=2, HOLD_LOW=1, ENABLE=1:
  - LEVEL reaches 31 exactly 124 cycles after STATE=1.
  - HOLD_HI lasts 8 cycles.
  - Fall to 0 takes 62 cycles, with CYCLE_DONE on the edge LEVEL hits 0.
  - HOLD_LO lasts 2 cycles, then RISE.
- RISE_DIV=0, HOLD_HIGH=0, HOLD_LOW=0 → triangle wave with LEVEL changing every cycle. STATE never enters 2 or 4. LEVEL_STB is high continuously.
- ENABLE dropped at LEVEL=12 in RISE → FALL next edge, LEVEL decrements 12→0, then IDLE. ENABLE pulsed high during the fade has no effect.
- RST asserted asynchronously mid-FALL at LEVEL=20 → outputs are reset values before the next CLK edge. Release with ENABLE=1 → RISE from 0.
- Force STATE=6 → IDLE next edge. RISE_DIV lowered from 100 to 2 while pc=50 → tick on the next cycle, no wrap.

Source files
------------

// File: rtl/glow_pkg.sv
// Shared definitions for the LED glow envelope path: state encoding and level range.
package glow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } glow_state_t;

    function automatic int level_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/glow_prescaler.sv
// Step prescaler: ticks once every div+1 clocks; restart makes the current cycle count as zero.
// The >= compare lets a divisor lowered mid-count fire on the next cycle instead of wrapping.
module glow_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_restart,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_pc;
    logic [DIV_W-1:0] w_pc;

    // restart is raised for the first cycle after a state change, so the
    // count restarts from zero exactly at the edge the state changed.
    assign w_pc   = i_restart ? '0 : r_pc;
    assign o_tick = (w_pc >= i_div);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= '0;
        end else if (o_tick) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc + 1'b1;
        end
    end

endmodule

// File: rtl/glow_envelope.sv
// Brightness envelope FSM: ramps LEVEL up, holds, ramps down, holds off, repeating while enabled.
// Dropping ENABLE fades out from the current level and parks in IDLE.
module glow_envelope
    import glow_pkg::*;
#(
    parameter int LEVEL_W = 5,
    parameter int DIV_W   = 16,
    parameter int HOLD_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic [DIV_W-1:0]   i_rise_div,
    input  logic [DIV_W-1:0]   i_fall_div,
    input  logic [HOLD_W-1:0]  i_hold_high,
    input  logic [HOLD_W-1:0]  i_hold_low,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_level_stb,
    output logic [2:0]         o_state,
    output logic               o_cycle_done
);

    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(level_max(LEVEL_W));
    localparam logic [LEVEL_W-1:0] LVL_ONE = LEVEL_W'(1);

    glow_state_t         r_state;
    logic [LEVEL_W-1:0]  r_level;
    logic                r_level_stb;
    logic                r_cycle_done;
    logic                r_restart;
    logic                r_fading;
    logic [HOLD_W-1:0]   r_hc;

    logic [DIV_W-1:0]    w_div;
    logic                w_tick;
    logic                w_hold_hi_done;
    logic                w_hold_lo_done;

    assign w_div = (r_state == ST_FALL || r_state == ST_HOLD_LO) ? i_fall_div : i_rise_div;

    assign w_hold_hi_done = ({1'b0, r_hc} + 1'b1) >= {1'b0, i_hold_high};
    assign w_hold_lo_done = ({1'b0, r_hc} + 1'b1) >= {1'b0, i_hold_low};

    glow_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_div     (w_div),
        .i_restart (r_restart),
        .o_tick    (w_tick)
    );

    // Every transition raises r_restart and clears r_hc so each state starts a fresh step count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_level      <= '0;
            r_level_stb  <= 1'b0;
            r_cycle_done <= 1'b0;
            r_restart    <= 1'b0;
            r_fading     <= 1'b0;
            r_hc         <= '0;
        end else begin
            r_level_stb  <= 1'b0;
            r_cycle_done <= 1'b0;
            r_restart    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_level  <= '0;
                    r_fading <= 1'b0;
                    if (i_enable) begin
                        r_state   <= ST_RISE;
                        r_restart <= 1'b1;
                        r_hc      <= '0;
                    end
                end
                ST_RISE: begin
                    if (!i_enable) begin
                        r_fading  <= 1'b1;
                        r_state   <= (r_level == '0) ? ST_IDLE : ST_FALL;
                        r_restart <= 1'b1;
                        r_hc      <= '0;
                    end else if (w_tick) begin
                        if (r_level != LVL_MAX) begin
                            r_level     <= r_level + 1'b1;
                            r_level_stb <= 1'b1;
                        end
                        if (r_level >= LVL_MAX - 1'b1) begin
                            r_state   <= (i_hold_high == '0) ? ST_FALL : ST_HOLD_HI;
                            r_restart <= 1'b1;
                            r_hc      <= '0;
                        end
                    end
                end
                ST_HOLD_HI: begin
                    if (!i_enable) begin
                        r_fading  <= 1'b1;
                        r_state   <= ST_FALL;
                        r_restart <= 1'b1;
                        r_hc      <= '0;
                    end else if (w_tick) begin
                        if (w_hold_hi_done) begin
                            r_state   <= ST_FALL;
                            r_restart <= 1'b1;
                            r_hc      <= '0;
                        end else begin
                            r_hc <= r_hc + 1'b1;
                        end
                    end
                end
                ST_FALL: begin
                    // Once a fade-out has begun, a re-asserted ENABLE must not resume the cycle.
                    if (!i_enable) begin
                        r_fading <= 1'b1;
                    end
                    if (w_tick) begin
                        if (r_level != '0) begin
                            r_level     <= r_level - 1'b1;
                            r_level_stb <= 1'b1;
                        end
                        if (r_level <= LVL_ONE) begin
                            r_cycle_done <= 1'b1;
                            r_restart    <= 1'b1;
                            r_hc         <= '0;
                            if (!i_enable || r_fading) begin
                                r_state <= ST_IDLE;
                            end else if (i_hold_low == '0) begin
                                r_state <= ST_RISE;
                            end else begin
                                r_state <= ST_HOLD_LO;
                            end
                        end
                    end
                end
                ST_HOLD_LO: begin
                    if (!i_enable) begin
                        r_state   <= ST_IDLE;
                        r_restart <= 1'b1;
                        r_hc      <= '0;
                    end else if (w_tick) begin
                        if (w_hold_lo_done) begin
                            r_state   <= ST_RISE;
                            r_restart <= 1'b1;
                            r_hc      <= '0;
                        end else begin
                            r_hc <= r_hc + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_level   <= '0;
                    r_restart <= 1'b1;
                    r_hc      <= '0;
                end
            endcase
        end
    end

    assign o_level      = r_level;
    assign o_level_stb  = r_level_stb;
    assign o_state      = r_state;
    assign o_cycle_done = r_cycle_done;

endmodule

// File: tb/tb_glow_envelope.sv
// Scoreboard bench: a timeline model predicts every LEVEL strobe (cycle, level, state, done);
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_glow_envelope;

    localparam int LMAX = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] rdiv, fdiv;
    logic [7:0]  hh, hl;
    logic [4:0]  o_level;
    logic        o_level_stb;
    logic [2:0]  o_state;
    logic        o_cycle_done;

    glow_envelope #(.LEVEL_W(5), .DIV_W(16), .HOLD_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (en),
        .i_rise_div   (rdiv),
        .i_fall_div   (fdiv),
        .i_hold_high  (hh),
        .i_hold_low   (hl),
        .o_level      (o_level),
        .o_level_stb  (o_level_stb),
        .o_state      (o_state),
        .o_cycle_done (o_cycle_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int lvl;
        int st;
        int cd;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  stb_seen = 0;

    always @(negedge clk) begin
        ev_t e;
        if (!rst && (o_level_stb || o_cycle_done)) begin
            stb_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: cyc=%0d level=%0d state=%0d done=%0d, expected no strobe",
                         cyc, o_level, o_state, o_cycle_done);
            end else begin
                e = exp_q.pop_front();
                if (e.t != cyc || e.lvl != int'(o_level) || e.st != int'(o_state) ||
                    e.cd != int'(o_cycle_done) || !o_level_stb) begin
                    errors++;
                    $display("FAIL strobe_event: got cyc=%0d level=%0d state=%0d done=%0d stb=%0d, expected cyc=%0d level=%0d state=%0d done=%0d",
                             cyc, o_level, o_state, o_cycle_done, o_level_stb, e.t, e.lvl, e.st, e.cd);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic void push_ev(input int t, input int lvl, input int st, input int cd);
        ev_t e;
        e.t = t; e.lvl = lvl; e.st = st; e.cd = cd;
        exp_q.push_back(e);
    endfunction

    // Fade-out from level L, starting at the edge D that first sees ENABLE low.
    function automatic int fade(input int d, input int l, input int pf);
        if (l == 0) return d;
        for (int k = 1; k <= l; k++)
            push_ev(d + k * pf, l - k, (k == l) ? 0 : 3, (k == l) ? 1 : 0);
        return d + l * pf;
    endfunction

    // Timeline of one enabled run: RISE entered at edge e, ENABLE first sampled low at edge d.
    // Returns the edge at which IDLE is re-entered.
    function automatic int model_run(input int e, input int d, input int rd, input int fd,
                                     input int h1, input int h0);
        int t;
        int te;
        int pr;
        int pf;
        t  = e;
        pr = rd + 1;
        pf = fd + 1;
        for (int period = 0; period < 1000; period++) begin
            for (int k = 1; k <= LMAX; k++) begin
                te = t + k * pr;
                if (d <= te) return fade(d, k - 1, pf);
                push_ev(te, k, (k == LMAX) ? ((h1 > 0) ? 2 : 3) : 1, 0);
            end
            t = t + LMAX * pr;
            if (h1 > 0) begin
                if (d <= t + h1 * pr) return fade(d, LMAX, pf);
                t = t + h1 * pr;
            end
            for (int k = 1; k <= LMAX; k++) begin
                te = t + k * pf;
                if (k < LMAX) begin
                    push_ev(te, LMAX - k, 3, 0);
                end else if (d <= te) begin
                    push_ev(te, 0, 0, 1);
                    return te;
                end else begin
                    push_ev(te, 0, (h0 > 0) ? 4 : 1, 1);
                end
            end
            t = t + LMAX * pf;
            if (h0 > 0) begin
                if (d <= t + h0 * pf) return d;
                t = t + h0 * pf;
            end
        end
        return t;
    endfunction

    task automatic finish_run(input int d, input int tend, input bit pulse, input string tag);
        tick_to(d - 1);
        en = 1'b0;
        if (pulse && tend >= d + 4) begin
            tick_to(d + 1);
            en = 1'b1;
            tick_to(d + 2);
            en = 1'b0;
        end
        tick_to(tend + 2);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle_state"}, int'(o_state), 0);
        chk({tag, "_idle_level"}, int'(o_level), 0);
    endtask

    task automatic run_env(input int r, input int f, input int h1, input int h0,
                           input int span, input bit pulse, input string tag);
        int e;
        int d;
        int tend;
        @(negedge clk);
        rdiv = 16'(r); fdiv = 16'(f); hh = 8'(h1); hl = 8'(h0);
        en = 1'b1;
        e = cyc + 1;
        d = e + span;
        tend = model_run(e, d, r, f, h1, h0);
        finish_run(d, tend, pulse, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int e;
        int d;
        int tend;
        int r, f, h1, h0, per;
        rst = 1'b1; en = 1'b0;
        rdiv = '0; fdiv = '0; hh = '0; hl = '0;
        @(negedge clk);
        chk("reset_level", int'(o_level), 0);
        chk("reset_state", int'(o_state), 0);
        chk("reset_stb", int'(o_level_stb), 0);
        chk("reset_done", int'(o_cycle_done), 0);
        #3 rst = 1'b0;

        tick_to(cyc + 1000);
        chk("idle_level", int'(o_level), 0);
        chk("idle_state", int'(o_state), 0);
        chk("idle_no_strobes", stb_seen, 0);

        run_env(3, 1, 2, 1, 450, 1'b0, "shape");
        run_env(0, 0, 0, 0, 150, 1'b1, "triangle");

        // Disable once LEVEL reaches 12 in RISE, with an ignored ENABLE pulse during the fade.
        run_env(1, 2, 3, 3, 12 * 2 + 1, 1'b1, "drop12");

        // Asynchronous reset in FALL at LEVEL=20, then restart from 0.
        @(negedge clk);
        rdiv = 16'd0; fdiv = 16'd2; hh = 8'd1; hl = 8'd1;
        en = 1'b1;
        e = cyc + 1;
        tend = model_run(e, e + 5000, 0, 2, 1, 1);
        tick_to(e + 65);
        chk("pre_reset_level", int'(o_level), 20);
        chk("pre_reset_state", int'(o_state), 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_level", int'(o_level), 0);
        chk("async_rst_state", int'(o_state), 0);
        chk("async_rst_stb", int'(o_level_stb), 0);
        chk("async_rst_done", int'(o_cycle_done), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        e = cyc + 1;
        d = e + 40;
        tend = model_run(e, d, 0, 2, 1, 1);
        finish_run(d, tend, 1'b0, "post_reset");

        // Divisor lowered from 100 to 2 while the count sits at 50.
        @(negedge clk);
        rdiv = 16'd100; fdiv = 16'd1; hh = 8'd0; hl = 8'd0;
        en = 1'b1;
        e = cyc + 1;
        push_ev(e + 51, 1, 1, 0);
        push_ev(e + 54, 2, 1, 0);
        d = e + 55;
        tend = fade(d, 2, 2);
        tick_to(e + 50);
        rdiv = 16'd2;
        finish_run(d, tend, 1'b0, "div_lower");

        for (int i = 0; i < 15; i++) begin
            r  = $urandom_range(0, 3);
            f  = $urandom_range(0, 3);
            h1 = $urandom_range(0, 3);
            h0 = $urandom_range(0, 3);
            per = LMAX * (r + 1) + h1 * (r + 1) + LMAX * (f + 1) + h0 * (f + 1);
            run_env(r, f, h1, h0, $urandom_range(1, 2 * per + 10), 1'($urandom_range(0, 1)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
